// File: rtl/dmem_rmw_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// The extract/merge functions are reusable by the core's load path.
package dmem_rmw_pkg;

  typedef enum logic [2:0] {
    MEM_DT_BYTE,
    MEM_DT_HALF,
    MEM_DT_WORD,
    MEM_DT_UBYTE,
    MEM_DT_UHALF
  } mem_dt_e;

  typedef enum logic [1:0] {
    ENONE,
    EALIGN,
    EADDR
  } errno_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WB
  } dmem_rmw_st_e;

  function automatic logic misaligned(mem_dt_e dt, logic [1:0] a);
    case (dt)
      MEM_DT_HALF, MEM_DT_UHALF: return a[0];
      MEM_DT_WORD:               return a != 2'b00;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(logic [31:0] w, logic [1:0] a, mem_dt_e dt);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    case (dt)
      MEM_DT_BYTE:  return {{24{b[7]}}, b};
      MEM_DT_UBYTE: return {24'h000000, b};
      MEM_DT_HALF:  return {{16{h[15]}}, h};
      MEM_DT_UHALF: return {16'h0000, h};
      default:      return w;
    endcase
  endfunction

  // Signedness is irrelevant for stores: only the lane size matters.
  function automatic logic [31:0] lane_merge(logic [31:0] w, logic [31:0] d, logic [1:0] a,
                                             mem_dt_e dt);
    logic [31:0] m;
    m = w;
    case (dt)
      MEM_DT_BYTE, MEM_DT_UBYTE: m[8*a +: 8] = d[7:0];
      MEM_DT_HALF, MEM_DT_UHALF: m[16*a[1] +: 16] = d[15:0];
      default:                   m = d;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_rmw_if.sv
// Core-side load/store port between the initiator and dmem_rmw.
interface dmem_rmw_if;
  import dmem_rmw_pkg::*;

  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  mem_dt_e     dt;
  logic [31:0] rd;
  logic        done;
  logic        busy;
  errno_e      err;

  modport master (output req, addr, we, wd, dt, input rd, done, busy, err);
  modport slave  (input req, addr, we, wd, dt, output rd, done, busy, err);
endinterface

// File: rtl/dmem_rmw_ram.sv
// Single-port word RAM with synchronous read and no byte enables.
module dmem_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/dmem_rmw.sv
// Data-memory responder: sub-word stores via read-modify-write, extended loads.
//   state | meaning
//   IDLE  | accept req; errors and word stores complete here
//   RD    | RAM read word arriving
//   WB    | extract load lane or write merged store word
module dmem_rmw
  import dmem_rmw_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic      clk,
  input  logic      rst,
  dmem_rmw_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_rmw_st_e state;
  logic [AW-1:0] a_word;
  logic [1:0]    a_lane;
  logic          l_we;
  logic [15:0]   l_wd;
  mem_dt_e       l_dt;
  logic [31:0]   rd_q;
  logic          done_q;
  logic          busy_q;
  errno_e        err_q;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wd;
  logic [31:0]   ram_rd;

  logic req_align_bad;
  logic req_oob;
  logic req_wstore;

  assign req_align_bad = misaligned(bus.dt, bus.addr[1:0]);
  assign req_oob       = bus.addr[31:2] >= 30'(DEPTH_WORDS);
  assign req_wstore    = bus.we && (bus.dt == MEM_DT_WORD) && !req_align_bad && !req_oob;

  // The RAM address follows the live bus in IDLE so the read is issued at the accept edge.
  assign ram_addr = (state == IDLE) ? bus.addr[AW+1:2] : a_word;
  assign ram_wd   = (state == IDLE) ? bus.wd
                                    : lane_merge(ram_rd, {16'h0000, l_wd}, a_lane, l_dt);
  assign ram_we   = !rst && (((state == IDLE) && bus.req && req_wstore) ||
                             ((state == WB) && l_we));

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wd   (ram_wd),
    .rd   (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_q   <= 32'h0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= ENONE;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            a_word <= bus.addr[AW+1:2];
            a_lane <= bus.addr[1:0];
            l_we   <= bus.we;
            l_wd   <= bus.wd[15:0];
            l_dt   <= bus.dt;
            if (req_align_bad) begin
              err_q  <= EALIGN;
              done_q <= 1'b1;
            end else if (req_oob) begin
              err_q  <= EADDR;
              done_q <= 1'b1;
            end else if (req_wstore) begin
              err_q  <= ENONE;
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              state  <= RD;
            end
          end
        end
        RD: state <= WB;
        WB: begin
          if (!l_we) rd_q <= lane_extract(ram_rd, a_lane, l_dt);
          err_q  <= ENONE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd   = rd_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: doc/dmem_rmw.md
# dmem_rmw

Data-memory responder for the CPU load/store port. It accepts one access at a time (byte, halfword or word; load or store) from the core-side initiator. It performs the access on a word-wide single-port RAM that has no byte enables, using read-modify-write for sub-word stores, and it returns sign- or zero-extended load data. It sits between the core's data port and the data RAM, and is the responding end of the store and load traffic the core issues.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit RAM words; byte address range 0 .. 4*DEPTH_WORDS-1.
- INIT_FILE, "": optional $readmemh image for the RAM; empty means no init.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  access request, sampled only in IDLE.
- addr  in  32  byte address.
- we  in  1  1 = store, 0 = load.
- wd  in  32  store data; low byte/half/word used per dt.
- dt  in  mem_dt_e  access type: MEM_DT_BYTE, MEM_DT_HALF, MEM_DT_WORD, MEM_DT_UBYTE, MEM_DT_UHALF.
- rd  out  32  extended load data; holds until the next load completes.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high while an accepted access is in flight.
- err  out  errno_e  status of the last completed access: ENONE, EALIGN, EADDR.

## Operation
- FSM states: IDLE, RD, WB.
- IDLE with req=1: latch addr, we, wd and dt.
  - If the access is misaligned (half/uhalf with addr[0]=1, or word with addr[1:0]≠0): set err=EALIGN, pulse done, stay in IDLE. No RAM access.
  - If addr[31:2] ≥ DEPTH_WORDS: set err=EADDR, pulse done, no RAM access.
  - Word store: write the RAM at that edge, set err=ENONE, pulse done, stay in IDLE.
  - Any other access (load or sub-word store): issue a RAM read and go to RD.
- RD: the RAM word is available. Go to WB.
- WB:
  - Load: rd ← extracted lane, extended per dt.
  - Sub-word store: write the merged word.
  - In both cases set err=ENONE, pulse done and return to IDLE.
- Lane select:
  - Byte: lane addr[1:0], bits 8*addr[1:0] +: 8.
  - Half: addr[1], bits 16*addr[1] +: 16.
- Extension:
  - BYTE and HALF sign-extend.
  - UBYTE and UHALF zero-extend.
  - A store with UBYTE/UHALF is treated as BYTE/HALF.
- Merge: replace only the selected lane with wd[7:0] or wd[15:0]; the other lanes keep their RAM value.
- req outside IDLE is ignored. The initiator holds or reissues after done.
- RAM contents are never modified by rst or by error accesses.

## Timing
- Reset values: state IDLE, rd=0, done=0, busy=0, err=ENONE.
- Let edge E0 be the edge that accepts the request.
- Latency:
  - Error access or word store: done high in the cycle after E0; busy stays 0.
  - Load or sub-word store: busy high after E0 and after E1; done high in the cycle after E2.
  - rd is valid in the done cycle of a load.
- done is registered. busy=0 in the done cycle, and a req present in that cycle is accepted, so back-to-back accesses are supported.
- Load throughput is 1 access per 3 cycles; word store throughput is 1 access per cycle.
- rst mid-operation:
  - Abandons the access; no write occurs.
  - If rst coincides with the WB edge, rst wins: no write, no done, rd unchanged at 0.
- Store-then-load to the same word returns the new data; the write completes at or before the done edge.

## Structure
- Shared package / headers:
  - mem_dt_e stays in mem.svh.
  - errno_e (ENONE, EALIGN, EADDR) stays in errno.svh.
  - FSM state enum dmem_rmw_st_e, lane-extract function and merge function go in mem.svh so the core's load path can reuse them.
- One sub-module: dmem_ram. It is a single-port, synchronous-read, word-addressed RAM (clk, addr, we, wd, rd) with DEPTH_WORDS and INIT_FILE, no reset.

## Test plan
- Preload word 5 = 0x11223344. Store half 0xdeadc0de at addr 22 → done in the cycle after E2; word 5 = 0xc0de3344; err=ENONE.
- Preload word 6 = 0x80ff7f01. Loads return:
  - byte at 27 → 0xffffff80.
  - ubyte at 27 → 0x00000080.
  - half at 26 → 0xffff80ff.
  - uhalf at 24 → 0x00007f01.
  - word at 24 → 0x80ff7f01.
- Word store 0xc001c0de at addr 40 → done the cycle after E0, busy never high; a following word load at 40 returns 0xc001c0de.
- Misaligned half at addr 21, and word store at addr 4*DEPTH_WORDS → err=EALIGN and err=EADDR respectively; done the cycle after E0; RAM unchanged.
- Byte store 0x00 at addr 20 held with req=1 continuously, followed by a load at 20 → the second access is accepted in the done cycle; req during busy produces no extra access; the load returns 0x00000000.
- Byte store 0xab at addr 20 over 0x11223344, with rst asserted for the E2 edge → word 5 stays 0x11223344; rd=0, done=0, busy=0, err=ENONE after reset.
